// File: rtl/alu_op_decoder.sv
// Purpose: RV32I decode stage; turns instruction words into alu_op, register indices and immediate.
// Latency: 1 cycle from an accepted instruction to the outputs when the buffer is empty.
// Backpressure: 2-entry output buffer; in_ready is state-registered (low only when FULL), no comb ready path.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   flush                 synchronous drop of buffered and incoming instructions
//   in_valid/in_ready     instruction handshake; instr is the 32-bit RV32I word
//   out_valid/out_ready   head-entry handshake towards execute
//   alu_op,rs1,rs2,rd,imm,illegal  decoded fields of the registered head entry
module alu_op_decoder #(
  parameter int unsigned XLEN       = 32,
  parameter logic [3:0]  ILLEGAL_OP = 4'd15
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SRL = 4'd3;
  localparam logic [3:0] ALU_SRA = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_EQ  = 4'd8;
  localparam logic [3:0] ALU_GE  = 4'd9;
  localparam logic [3:0] ALU_LT  = 4'd10;
  localparam logic [3:0] ALU_NE  = 4'd11;

  // Shared by register and immediate ALU forms. Immediate forms ignore
  // funct7 except for shifts, where it selects logical/arithmetic.
  // Returns {legal, op}.
  function automatic logic [4:0] alu_decode(input logic [2:0] f3,
                                            input logic [6:0] f7,
                                            input logic       is_imm);
    logic [4:0] r;
    r = 5'd0;
    case (f3)
      3'b000: begin
        if (is_imm || f7 == F7_BASE) r = {1'b1, ALU_ADD};
        else if (f7 == F7_ALT)       r = {1'b1, ALU_SUB};
      end
      3'b001: if (f7 == F7_BASE) r = {1'b1, ALU_SLL};
      3'b101: begin
        if (f7 == F7_BASE)     r = {1'b1, ALU_SRL};
        else if (f7 == F7_ALT) r = {1'b1, ALU_SRA};
      end
      3'b111: if (is_imm || f7 == F7_BASE) r = {1'b1, ALU_AND};
      3'b110: if (is_imm || f7 == F7_BASE) r = {1'b1, ALU_OR};
      3'b100: if (is_imm || f7 == F7_BASE) r = {1'b1, ALU_XOR};
      3'b010: if (is_imm || f7 == F7_BASE) r = {1'b1, ALU_LT};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_sh;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};

  entry_t     dec;
  logic       op_ok;
  logic [3:0] op_code;

  always_comb begin
    dec     = '0;
    op_ok   = 1'b0;
    op_code = ALU_ADD;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd  = instr[11:7];
    case (opcode)
      OPC_OP: {op_ok, op_code} = alu_decode(f3, f7, 1'b0);
      OPC_OP_IMM: begin
        {op_ok, op_code} = alu_decode(f3, f7, 1'b1);
        dec.rs2 = '0;
        dec.imm = (f3 == 3'b001 || f3 == 3'b101) ? imm_sh : imm_i;
      end
      OPC_LOAD: begin
        op_ok   = 1'b1;
        dec.rs2 = '0;
        dec.imm = imm_i;
      end
      OPC_STORE: begin
        op_ok   = 1'b1;
        dec.imm = imm_s;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        op_ok   = 1'b1;
        case (f3)
          3'b000:  op_code = ALU_EQ;
          3'b001:  op_code = ALU_NE;
          3'b100:  op_code = ALU_LT;
          3'b101:  op_code = ALU_GE;
          default: op_ok   = 1'b0;  // bltu/bgeu and reserved encodings
        endcase
      end
      default: op_ok = 1'b0;
    endcase
    dec.illegal = ~op_ok;
    dec.alu_op  = op_ok ? op_code : ILLEGAL_OP;
  end

  // Two-entry buffer: head drives the outputs, tail holds the second entry.
  state_t state_q, state_d;
  entry_t head_q, tail_q;
  logic   push, pop;
  logic   ld_head_in, ld_head_tail, ld_tail;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    ld_head_in   = 1'b0;
    ld_head_tail = 1'b0;
    ld_tail      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d    = HALF;
            ld_head_in = 1'b1;
          end
        end
        HALF: begin
          if (push && pop) begin
            ld_head_in = 1'b1;  // head retires, new entry replaces it
          end else if (push) begin
            state_d = FULL;
            ld_tail = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d      = HALF;
            ld_head_tail = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (ld_head_in)        head_q <= dec;
      else if (ld_head_tail) head_q <= tail_q;
      if (ld_tail)           tail_q <= dec;
    end
  end

  assign alu_op  = head_q.alu_op;
  assign rs1     = head_q.rs1;
  assign rs2     = head_q.rs2;
  assign rd      = head_q.rd;
  assign imm     = head_q.imm;
  assign illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Purpose: randomized and directed check of alu_op_decoder against a table-driven decode model.
// Latency: expected entries are queued on accepted pushes, compared while they sit at the head.
// Backpressure: out_ready is toggled to exercise the EMPTY/HALF/FULL occupancy.
module tb_alu_op_decoder;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        illegal;

  alu_op_decoder #(.XLEN(32), .ILLEGAL_OP(4'd15)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .illegal   (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_out = 0;
  int   n_mark;

  // Legal (funct7,funct3) pairs for register ops, keyed as funct7*8+funct3.
  localparam int R_KEY [9] = '{0, 256, 1, 5, 261, 7, 6, 4, 2};
  localparam int R_OP  [9] = '{0, 1,   2, 3, 4,   5, 6, 7, 10};
  localparam int B_F3  [4] = '{0, 1, 4, 5};
  localparam int B_OP  [4] = '{8, 11, 10, 9};

  function automatic int r_lookup(input int key);
    for (int i = 0; i < 9; i++)
      if (R_KEY[i] == key) return R_OP[i];
    return -1;
  endfunction

  function automatic int b_lookup(input int f3);
    for (int i = 0; i < 4; i++)
      if (B_F3[i] == f3) return B_OP[i];
    return -1;
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int opc, f3, f7, sw, code;
    opc   = int'(w[6:0]);
    f3    = int'(w[14:12]);
    f7    = int'(w[31:25]);
    sw    = int'($signed(w));
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.imm = 32'd0;
    code  = -1;
    case (opc)
      'h33: code = r_lookup(f7 * 8 + f3);
      'h13: begin
        e.rs2 = 5'd0;
        if (f3 == 1 || f3 == 5) begin
          code  = r_lookup(f7 * 8 + f3);
          e.imm = 32'(int'(w[24:20]));
        end else begin
          code  = r_lookup(f3);
          e.imm = 32'(sw >>> 20);
        end
      end
      'h03: begin
        e.rs2 = 5'd0;
        code  = 0;
        e.imm = 32'(sw >>> 20);
      end
      'h23: begin
        code  = 0;
        e.imm = 32'((sw >>> 25) * 32 + int'(w[11:7]));
      end
      'h63: begin
        code  = b_lookup(f3);
        e.imm = 32'((sw >>> 31) * 4096 + int'(w[7]) * 2048
                    + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      end
      default: code = -1;
    endcase
    e.ill = (code < 0);
    e.op  = (code < 0) ? 4'd15 : 4'(code);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0, 1, 2: w[6:0] = 7'h33;
      3, 4, 5: w[6:0] = 7'h13;
      6:       w[6:0] = 7'h03;
      7:       w[6:0] = 7'h23;
      8, 9:    w[6:0] = 7'h63;
      10:      w[6:0] = 7'h37;
      11:      w[6:0] = 7'h6F;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy and head contents checked every cycle away from the edge.
  always @(negedge clock) begin
    if (reset_n) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (out_valid && exp_q.size() != 0) begin
        mon_e = exp_q[0];
        check("head", {12'd0, alu_op, rs1, rs2, rd, imm, illegal}, {12'd0, mon_e});
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  // Drive one cycle (called just after a rising edge); book the push at mid-cycle.
  task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f);
    in_valid  = v;
    instr     = w;
    out_ready = r;
    flush     = f;
    @(negedge clock);
    #1;
    if (reset_n) begin
      if (f) exp_q.delete();
      else if (v && in_ready) exp_q.push_back(model(w));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'd0;
    out_ready = 1'b0;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fields", {12'd0, alu_op, rs1, rs2, rd, imm, illegal}, 64'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // T1..T3: directed decodes with constant expectations.
    step(1'b1, 32'h002081B3, 1'b1, 1'b0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_fields", {44'd0, alu_op, rs1, rs2, rd, illegal}, {44'd0, 4'd0, 5'd1, 5'd2, 5'd3, 1'b0});
    step(1'b1, 32'h402081B3, 1'b1, 1'b0);
    check("t2_sub", 64'(alu_op), 64'd1);
    step(1'b1, 32'hFFF00293, 1'b1, 1'b0);
    check("t2_addi", {32'd0, 12'd0, alu_op, rd, rs2, 1'b0, illegal},
          {32'd0, 12'd0, 4'd0, 5'd5, 5'd0, 1'b0, 1'b0});
    check("t2_addi_imm", 64'(imm), 64'hFFFFFFFF);
    step(1'b1, 32'hFE209EE3, 1'b1, 1'b0);
    check("t3_bne", 64'(alu_op), 64'd11);
    check("t3_bne_imm", 64'(imm), 64'hFFFFFFFC);
    step(1'b1, 32'h0020B1B3, 1'b1, 1'b0);
    check("t3_sltu", {59'd0, illegal, alu_op}, {59'd0, 1'b1, 4'd15});
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // T4: fill under backpressure, third word held until space frees.
    step(1'b1, 32'h00A00093, 1'b0, 1'b0);
    step(1'b1, 32'h40B50633, 1'b0, 1'b0);
    check("t4_full_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h00C5F6B3, 1'b0, 1'b0);
    step(1'b1, 32'h00C5F6B3, 1'b1, 1'b0);
    step(1'b1, 32'h00C5F6B3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // T5: flush from FULL with an incoming word.
    step(1'b1, 32'h00100113, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 1'b0, 1'b0);
    step(1'b1, 32'h00300213, 1'b0, 1'b1);
    check("t5_flush_valid", 64'(out_valid), 64'd0);
    check("t5_flush_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

    // T6: steady push&pop in HALF, then an asynchronous reset pulse.
    step(1'b1, rand_instr(), 1'b0, 1'b0);
    n_mark = n_out;
    for (int i = 0; i < 10; i++) step(1'b1, rand_instr(), 1'b1, 1'b0);
    check("t6_outputs", 64'(n_out - n_mark), 64'd10);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_fields", {12'd0, alu_op, rs1, rs2, rd, imm, illegal}, 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
